// File: rtl/wvb_reader_pkg.sv
// Shared definitions for the waveform-buffer round-robin readout sequencer.
// FSM encoding is kept as plain constants so legacy blocks can decode the state bits directly.
package wvb_reader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_REQ       = 2'd1;
  localparam state_t S_BUSY_WAIT = 2'd2;
  localparam state_t S_DONE      = 2'd3;

  localparam int RDCNT_W = 32;

endpackage

// File: rtl/wvb_rr_reader_if.sv
// Handshake bundle between the readout sequencer, the per-channel header FIFOs,
// the data/header muxes and the external read controller.
interface wvb_rr_reader_if #(
  parameter int N_CHANNELS = 24,
  parameter int P_CHAN_W   = 5
);

  logic [N_CHANNELS-1:0] hdr_empty;
  logic [N_CHANNELS-1:0] hdr_rdreq;
  logic [P_CHAN_W-1:0]   chan_sel;
  logic                  rd_ctrl_req;
  logic                  rd_ctrl_ack;
  logic                  dpram_busy;
  logic                  dpram_run;

  modport master (
    input  hdr_empty, rd_ctrl_ack, dpram_busy,
    output hdr_rdreq, chan_sel, rd_ctrl_req, dpram_run
  );

  modport slave (
    output hdr_empty, rd_ctrl_ack, dpram_busy,
    input  hdr_rdreq, chan_sel, rd_ctrl_req, dpram_run
  );

endinterface

// File: rtl/posedge_detector.sv
// Registered rising-edge detector: one-cycle pulse the cycle after d_i is first seen high.
module posedge_detector (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);

  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= d_i;
      pulse_q <= d_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/rr_priority_sel.sv
// Combinational rotating-priority encoder: returns the first set request at or after
// start_i, wrapping from N-1 back to 0. start_i must be below N.
module rr_priority_sel #(
  parameter int N = 24,
  parameter int W = 5
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);

  int          cand;
  logic [W-1:0] candIdx;

  // Single pass over all offsets so empty channels cost no extra cycles.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    candIdx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(start_i) + k;
      if (cand >= N) cand = cand - N;
      candIdx = W'(cand);
      if (!valid_o && req_i[candIdx]) begin
        valid_o = 1'b1;
        idx_o   = candIdx;
      end
    end
  end

endmodule

// File: rtl/wvb_rr_reader.sv
// Multi-channel waveform-buffer readout sequencer: round-robin channel grant, read-controller
// handshake, DPRAM drain tracking, handshake watchdog and a saturating readout counter.
module wvb_rr_reader
  import wvb_reader_pkg::*;
#(
  parameter int N_CHANNELS  = 24,
  parameter int P_CHAN_W    = 5,
  parameter int P_TIMEOUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [N_CHANNELS-1:0]  chan_mask_i,
  input  logic [P_TIMEOUT_W-1:0] timeout_cycles_i,
  input  logic                   clr_err_i,
  wvb_rr_reader_if.master        bus,
  output logic                   rd_busy_o,
  output logic                   timeout_err_o,
  output logic [RDCNT_W-1:0]     n_readouts_o
);

  localparam logic [P_CHAN_W-1:0] LAST_CH = P_CHAN_W'(N_CHANNELS - 1);

  state_t                  state_q, state_d;
  logic [P_CHAN_W-1:0]     chanSel_q, chanSel_d;
  logic [N_CHANNELS-1:0]   hdrRdreq_q, hdrRdreq_d;
  logic                    rdCtrlReq_q, rdCtrlReq_d;
  logic [P_CHAN_W-1:0]     lastGrant_q, lastGrant_d;
  logic [P_TIMEOUT_W-1:0]  wdCnt_q, wdCnt_d;
  logic                    timeoutErr_q, timeoutErr_d;
  logic [RDCNT_W-1:0]      nReadouts_q, nReadouts_d;

  logic                    softRst;
  logic [N_CHANNELS-1:0]   elig;
  logic [P_CHAN_W-1:0]     startIdx;
  logic                    grantValid;
  logic [P_CHAN_W-1:0]     winner;
  logic                    inWatch;
  logic                    timeoutHit;
  logic                    dpramRun;

  // en low behaves like reset for everything except the readout counter.
  assign softRst  = rst | ~en_i;
  assign elig     = chan_mask_i & ~bus.hdr_empty;
  assign startIdx = (lastGrant_q == LAST_CH) ? '0 : lastGrant_q + P_CHAN_W'(1);

  rr_priority_sel #(
    .N (N_CHANNELS),
    .W (P_CHAN_W)
  ) u_prio (
    .req_i   (elig),
    .start_i (startIdx),
    .valid_o (grantValid),
    .idx_o   (winner)
  );

  posedge_detector u_ack_edge (
    .clk     (clk),
    .rst     (softRst),
    .d_i     (bus.rd_ctrl_ack),
    .pulse_o (dpramRun)
  );

  assign inWatch    = (state_q == S_REQ) || (state_q == S_BUSY_WAIT);
  assign timeoutHit = (timeout_cycles_i != '0) &&
                      (wdCnt_q == timeout_cycles_i - P_TIMEOUT_W'(1));

  always_comb begin
    state_d      = state_q;
    chanSel_d    = chanSel_q;
    hdrRdreq_d   = '0;
    rdCtrlReq_d  = rdCtrlReq_q;
    lastGrant_d  = lastGrant_q;
    wdCnt_d      = inWatch ? wdCnt_q + P_TIMEOUT_W'(1) : wdCnt_q;
    timeoutErr_d = timeoutErr_q & ~clr_err_i;
    nReadouts_d  = nReadouts_q;

    case (state_q)
      S_IDLE: begin
        if (grantValid && !bus.dpram_busy && !bus.rd_ctrl_ack) begin
          state_d     = S_REQ;
          chanSel_d   = winner;
          hdrRdreq_d  = N_CHANNELS'(1) << winner;
          rdCtrlReq_d = 1'b1;
          wdCnt_d     = '0;
        end
      end
      S_REQ: begin
        if (bus.rd_ctrl_ack) begin
          rdCtrlReq_d = 1'b0;
          state_d     = S_BUSY_WAIT;
          if (nReadouts_q != '1) nReadouts_d = nReadouts_q + RDCNT_W'(1);
        end
      end
      S_BUSY_WAIT: begin
        if (bus.dpram_busy) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.dpram_busy) begin
          state_d     = S_IDLE;
          lastGrant_d = chanSel_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog overrides the handshake; an ack in the same cycle still counts.
    if (inWatch && timeoutHit) begin
      timeoutErr_d = 1'b1;
      rdCtrlReq_d  = 1'b0;
      state_d      = S_IDLE;
      lastGrant_d  = chanSel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (softRst) begin
      state_q      <= S_IDLE;
      chanSel_q    <= '0;
      hdrRdreq_q   <= '0;
      rdCtrlReq_q  <= 1'b0;
      lastGrant_q  <= LAST_CH;
      wdCnt_q      <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chanSel_q    <= chanSel_d;
      hdrRdreq_q   <= hdrRdreq_d;
      rdCtrlReq_q  <= rdCtrlReq_d;
      lastGrant_q  <= lastGrant_d;
      wdCnt_q      <= wdCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nReadouts_q <= '0;
    end else if (en_i) begin
      nReadouts_q <= nReadouts_d;
    end
  end

  assign bus.chan_sel    = chanSel_q;
  assign bus.hdr_rdreq   = hdrRdreq_q;
  assign bus.rd_ctrl_req = rdCtrlReq_q;
  assign bus.dpram_run   = dpramRun;
  assign rd_busy_o       = (state_q != S_IDLE);
  assign timeout_err_o   = timeoutErr_q;
  assign n_readouts_o    = nReadouts_q;

endmodule

// File: tb/tb_wvb_rr_reader.sv
// Directed self-checking bench for wvb_rr_reader: grant order, masking, watchdog,
// reset/enable behaviour and counter saturation with hand-computed expectations.
module tb_wvb_rr_reader;

  localparam int N  = 24;
  localparam int CW = 5;
  localparam int TW = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic [N-1:0]  chanMask;
  logic [TW-1:0] timeoutCycles;
  logic          clrErr;
  logic          rdBusy;
  logic          timeoutErr;
  logic [31:0]   nReadouts;

  int          assertCount;
  int          failCount;
  int          runSeen;
  logic [31:0] nExp;

  wvb_rr_reader_if #(.N_CHANNELS(N), .P_CHAN_W(CW)) bus ();

  wvb_rr_reader #(
    .N_CHANNELS  (N),
    .P_CHAN_W    (CW),
    .P_TIMEOUT_W (TW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en_i             (en),
    .chan_mask_i      (chanMask),
    .timeout_cycles_i (timeoutCycles),
    .clr_err_i        (clrErr),
    .bus              (bus),
    .rd_busy_o        (rdBusy),
    .timeout_err_o    (timeoutErr),
    .n_readouts_o     (nReadouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance n clocks and sample 1 time unit after each rising edge.
  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      runSeen += int'(bus.dpram_run);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] empty);
    chanMask      = mask;
    bus.hdr_empty = empty;
  endtask

  task automatic checkResetOutputs(input string tag, input logic [31:0] expN);
    checkOutput({tag, "_sel"},   32'(bus.chan_sel), 0);
    checkOutput({tag, "_rdreq"}, 32'(bus.hdr_rdreq), 0);
    checkOutput({tag, "_req"},   32'(bus.rd_ctrl_req), 0);
    checkOutput({tag, "_run"},   32'(bus.dpram_run), 0);
    checkOutput({tag, "_busy"},  32'(rdBusy), 0);
    checkOutput({tag, "_err"},   32'(timeoutErr), 0);
    checkOutput({tag, "_cnt"},   nReadouts, expN);
  endtask

  // Caller sets eligibility in the decision cycle; grant must appear after one clock.
  task automatic runReadout(input int expCh, input string tag);
    runSeen = 0;
    stepClock(1);
    checkOutput({tag, "_sel"},   32'(bus.chan_sel), expCh);
    checkOutput({tag, "_rdreq"}, 32'(bus.hdr_rdreq), 32'(1) << expCh);
    checkOutput({tag, "_req"},   32'(bus.rd_ctrl_req), 1);
    bus.hdr_empty[expCh] = 1'b1;
    stepClock(1);
    checkOutput({tag, "_rdreq1"}, 32'(bus.hdr_rdreq), 0);
    checkOutput({tag, "_hold"},   32'(bus.rd_ctrl_req), 1);
    bus.rd_ctrl_ack = 1'b1;
    stepClock(1);
    if (nExp != 32'hFFFF_FFFF) nExp = nExp + 1;
    checkOutput({tag, "_reqoff"}, 32'(bus.rd_ctrl_req), 0);
    checkOutput({tag, "_cnt"},    nReadouts, nExp);
    checkOutput({tag, "_run"},    32'(bus.dpram_run), 1);
    stepClock(1);
    bus.rd_ctrl_ack = 1'b0;
    bus.dpram_busy  = 1'b1;
    stepClock(1);
    checkOutput({tag, "_selhold"}, 32'(bus.chan_sel), expCh);
    bus.dpram_busy = 1'b0;
    stepClock(1);
    checkOutput({tag, "_idle"},  32'(rdBusy), 0);
    checkOutput({tag, "_runs"},  32'(runSeen), 1);
  endtask

  // Grant, ack and start of DPRAM drain, leaving the FSM parked in S_DONE.
  task automatic partialToDone(input int expCh, input string tag);
    stepClock(1);
    checkOutput({tag, "_sel"}, 32'(bus.chan_sel), expCh);
    bus.hdr_empty[expCh] = 1'b1;
    bus.rd_ctrl_ack      = 1'b1;
    stepClock(1);
    nExp = nExp + 1;
    bus.rd_ctrl_ack = 1'b0;
    bus.dpram_busy  = 1'b1;
    stepClock(2);
    checkOutput({tag, "_busy"}, 32'(rdBusy), 1);
    checkOutput({tag, "_cnt"},  nReadouts, nExp);
  endtask

  initial begin
    assertCount     = 0;
    failCount       = 0;
    runSeen         = 0;
    nExp            = 0;
    rst             = 1'b1;
    en              = 1'b1;
    timeoutCycles   = '0;
    clrErr          = 1'b0;
    bus.rd_ctrl_ack = 1'b0;
    bus.dpram_busy  = 1'b0;
    applyStimulus('1, '1);
    stepClock(2);
    checkResetOutputs("rst0", 0);
    rst = 1'b0;
    stepClock(2);
    checkOutput("noelig_busy", 32'(rdBusy), 0);

    // Single eligible channel 17 with channel 0 at top priority.
    bus.hdr_empty[17] = 1'b0;
    runReadout(17, "ch17");

    // Serve ch10, then 3/10/20 pending: rotation resumes after 10.
    bus.hdr_empty[10] = 1'b0;
    runReadout(10, "pre10");
    bus.hdr_empty[3]  = 1'b0;
    bus.hdr_empty[10] = 1'b0;
    bus.hdr_empty[20] = 1'b0;
    runReadout(20, "rr20");
    runReadout(3,  "rr3");
    runReadout(10, "rr10");

    // Masked channel is ignored; dpram_busy also blocks a grant.
    bus.hdr_empty[5] = 1'b0;
    chanMask[5]      = 1'b0;
    stepClock(3);
    checkOutput("mask_busy", 32'(rdBusy), 0);
    checkOutput("mask_req",  32'(bus.rd_ctrl_req), 0);
    chanMask[5]    = 1'b1;
    bus.dpram_busy = 1'b1;
    stepClock(2);
    checkOutput("dbusy_block", 32'(rdBusy), 0);
    bus.dpram_busy = 1'b0;
    runReadout(5, "unmask5");

    // Watchdog: ack never arrives.
    timeoutCycles    = 16'd100;
    bus.hdr_empty[7] = 1'b0;
    stepClock(1);
    checkOutput("wd_sel", 32'(bus.chan_sel), 7);
    bus.hdr_empty[7] = 1'b1;
    stepClock(99);
    checkOutput("wd_err99", 32'(timeoutErr), 0);
    checkOutput("wd_req99", 32'(bus.rd_ctrl_req), 1);
    stepClock(1);
    checkOutput("wd_err100", 32'(timeoutErr), 1);
    checkOutput("wd_req100", 32'(bus.rd_ctrl_req), 0);
    checkOutput("wd_idle",   32'(rdBusy), 0);
    checkOutput("wd_cnt",    nReadouts, nExp);
    timeoutCycles = '0;
    clrErr        = 1'b1;
    stepClock(1);
    clrErr = 1'b0;
    checkOutput("wd_clr", 32'(timeoutErr), 0);

    // rst while parked in S_DONE with seven readouts done.
    bus.hdr_empty[8] = 1'b0;
    partialToDone(8, "done8");
    checkOutput("pre_rst_cnt", nReadouts, 7);
    rst = 1'b1;
    stepClock(1);
    rst            = 1'b0;
    bus.dpram_busy = 1'b0;
    nExp           = 0;
    checkResetOutputs("rst_done", 0);

    // Rebuild seven readouts, then en=0 while in S_DONE.
    for (int i = 0; i < 6; i++) begin
      bus.hdr_empty[i] = 1'b0;
      runReadout(i, $sformatf("loop%0d", i));
    end
    bus.hdr_empty[6] = 1'b0;
    partialToDone(6, "done6");
    en = 1'b0;
    stepClock(1);
    bus.dpram_busy = 1'b0;
    checkResetOutputs("en_off", 7);
    stepClock(1);
    en = 1'b1;
    bus.hdr_empty[3] = 1'b0;
    bus.hdr_empty[9] = 1'b0;
    runReadout(3, "after_en");
    bus.hdr_empty[9] = 1'b1;

    // Counter saturation.
    force dut.nReadouts_q = 32'hFFFF_FFFF;
    stepClock(1);
    release dut.nReadouts_q;
    stepClock(1);
    checkOutput("sat_pre", nReadouts, 32'hFFFF_FFFF);
    nExp = 32'hFFFF_FFFF;
    bus.hdr_empty[12] = 1'b0;
    runReadout(12, "sat");
    checkOutput("sat_post", nReadouts, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
